// File: rtl/arc4_sequencer_if.sv
// Bus bundle between the ARC4 run controller, the sequencer and the three
// cipher engines (init, ksa, prga), including the shared S-memory port.
interface arc4_sequencer_if;
    // Run request / status
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [23:0] key_q;
    logic [1:0]  stage;

    // Engine start pulses and idle/done indications
    logic        init_en;
    logic        ksa_en;
    logic        prga_en;
    logic        init_rdy;
    logic        ksa_rdy;
    logic        prga_rdy;

    // Engine-side S-memory requests
    logic [7:0]  init_addr;
    logic [7:0]  ksa_addr;
    logic [7:0]  prga_addr;
    logic [7:0]  init_wrdata;
    logic [7:0]  ksa_wrdata;
    logic [7:0]  prga_wrdata;
    logic        init_wren;
    logic        ksa_wren;
    logic        prga_wren;

    // Single shared S-memory port
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;

    // Sequencer side
    modport slave (
        input  en, key,
        input  init_rdy, ksa_rdy, prga_rdy,
        input  init_addr, ksa_addr, prga_addr,
        input  init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, key_q, stage,
        output init_en, ksa_en, prga_en,
        output s_addr, s_wrdata, s_wren
    );

    // Controller / engine side
    modport master (
        output en, key,
        output init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr,
        output init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, key_q, stage,
        input  init_en, ksa_en, prga_en,
        input  s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_sequencer.sv
// ARC4 run sequencer: on an accepted start it latches the key, then starts the
// init, ksa and prga engines one after another, waiting for each to finish.
// The engine currently running owns the single S-memory port.
module arc4_sequencer (
    input  logic            clk,
    input  logic            rst,
    arc4_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START_INIT,
        WAIT_INIT,
        START_KSA,
        WAIT_KSA,
        START_PRGA,
        WAIT_PRGA
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [23:0] key_q_reg;
    logic [23:0] key_q_next;
    logic [1:0]  stage_sel;

    // State and latched key registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            key_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            key_q_reg <= key_q_next;
        end
    end

    // Next state, start pulses and stage decode; a start pulse is only raised
    // while the target engine reports idle, so it is sampled on that same edge.
    always_comb begin
        state_next  = state_reg;
        key_q_next  = key_q_reg;
        stage_sel   = 2'd0;
        bus.rdy     = 1'b0;
        bus.init_en = 1'b0;
        bus.ksa_en  = 1'b0;
        bus.prga_en = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    key_q_next = bus.key;
                    state_next = START_INIT;
                end
            end
            START_INIT: begin
                stage_sel   = 2'd1;
                bus.init_en = bus.init_rdy;
                if (bus.init_rdy) begin
                    state_next = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                stage_sel = 2'd1;
                if (bus.init_rdy) begin
                    state_next = START_KSA;
                end
            end
            START_KSA: begin
                stage_sel  = 2'd2;
                bus.ksa_en = bus.ksa_rdy;
                if (bus.ksa_rdy) begin
                    state_next = WAIT_KSA;
                end
            end
            WAIT_KSA: begin
                stage_sel = 2'd2;
                if (bus.ksa_rdy) begin
                    state_next = START_PRGA;
                end
            end
            START_PRGA: begin
                stage_sel   = 2'd3;
                bus.prga_en = bus.prga_rdy;
                if (bus.prga_rdy) begin
                    state_next = WAIT_PRGA;
                end
            end
            WAIT_PRGA: begin
                stage_sel = 2'd3;
                if (bus.prga_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.stage = stage_sel;
    assign bus.key_q = key_q_reg;

    // Engine requests gathered so the mux can be built per engine index
    logic [7:0] eng_addr     [3];
    logic [7:0] eng_wrdata   [3];
    logic       eng_wren     [3];
    logic [7:0] addr_gated   [3];
    logic [7:0] wrdata_gated [3];
    logic       wren_gated   [3];

    assign eng_addr[0]   = bus.init_addr;
    assign eng_addr[1]   = bus.ksa_addr;
    assign eng_addr[2]   = bus.prga_addr;
    assign eng_wrdata[0] = bus.init_wrdata;
    assign eng_wrdata[1] = bus.ksa_wrdata;
    assign eng_wrdata[2] = bus.prga_wrdata;
    assign eng_wren[0]   = bus.init_wren;
    assign eng_wren[1]   = bus.ksa_wren;
    assign eng_wren[2]   = bus.prga_wren;

    // Each engine's request is zeroed unless it owns the current stage, so
    // the OR below yields the owner's request, or all zeros while idle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mux
            logic owner;
            assign owner            = (stage_sel == 2'(gi + 1));
            assign addr_gated[gi]   = owner ? eng_addr[gi]   : 8'h00;
            assign wrdata_gated[gi] = owner ? eng_wrdata[gi] : 8'h00;
            assign wren_gated[gi]   = owner & eng_wren[gi];
        end
    endgenerate

    assign bus.s_addr   = addr_gated[0]   | addr_gated[1]   | addr_gated[2];
    assign bus.s_wrdata = wrdata_gated[0] | wrdata_gated[1] | wrdata_gated[2];
    assign bus.s_wren   = wren_gated[0]   | wren_gated[1]   | wren_gated[2];
endmodule

// File: tb/tb_arc4_sequencer.sv
// Bench for arc4_sequencer: behavioural engine models, a run-level reference
// model of the sequencing rules, and one task per scenario.
module tb_arc4_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arc4_sequencer_if bus();

    arc4_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [46:0] RESET_VEC = {1'b1, 2'd0, 3'b000, 24'h000000, 8'h00, 8'h00, 1'b0};

    // ---------------- engine models ----------------
    logic [2:0] eng_idle;
    int         eng_left [3];
    bit         rand_dur         = 1'b0;
    int         ksa_block_cycles = 0;
    int         stage2_cnt       = 0;
    logic [2:0] xen_w;
    logic [2:0] vis_rdy;

    assign xen_w        = {bus.prga_en, bus.ksa_en, bus.init_en};
    assign bus.init_rdy = eng_idle[0];
    assign bus.ksa_rdy  = eng_idle[1] && !(bus.stage == 2'd2 && ksa_block_cycles > stage2_cnt);
    assign bus.prga_rdy = eng_idle[2];
    assign vis_rdy      = {bus.prga_rdy, bus.ksa_rdy, bus.init_rdy};

    // Each engine goes busy when started and reports idle 5 edges later
    // (or a random 1..6 edges when rand_dur is set).
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                eng_idle[i] <= 1'b1;
                eng_left[i] <= 0;
            end else if (eng_idle[i]) begin
                if (xen_w[i]) begin
                    eng_idle[i] <= 1'b0;
                    eng_left[i] <= rand_dur ? int'($urandom_range(0, 5)) : 4;
                end
            end else if (eng_left[i] == 0) begin
                eng_idle[i] <= 1'b1;
            end else begin
                eng_left[i] <= eng_left[i] - 1;
            end
        end
        stage2_cnt <= (bus.stage == 2'd2) ? stage2_cnt + 1 : 0;
    end

    // ---------------- reference model ----------------
    // A run is a sequence of three phases; each phase first fires its engine
    // once (when that engine is idle) and then waits for it to become idle again.
    int          m_phase = 0;
    bit          m_fired = 1'b0;
    logic [23:0] m_key   = 24'h0;
    int          m_runs  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_fired <= 1'b0;
            m_key   <= 24'h0;
        end else if (m_phase == 0) begin
            if (bus.en) begin
                m_phase <= 1;
                m_fired <= 1'b0;
                m_key   <= bus.key;
                m_runs  <= m_runs + 1;
            end
        end else if (vis_rdy[2'(m_phase - 1)]) begin
            if (!m_fired) begin
                m_fired <= 1'b1;
            end else begin
                m_phase <= (m_phase == 3) ? 0 : m_phase + 1;
                m_fired <= 1'b0;
            end
        end
    end

    function automatic logic [46:0] exp_vec();
        logic [2:0] xen;
        logic [7:0] a;
        logic [7:0] d;
        logic       w;
        xen = 3'b000;
        a   = 8'h00;
        d   = 8'h00;
        w   = 1'b0;
        case (m_phase)
            1: begin a = bus.init_addr; d = bus.init_wrdata; w = bus.init_wren; end
            2: begin a = bus.ksa_addr;  d = bus.ksa_wrdata;  w = bus.ksa_wren;  end
            3: begin a = bus.prga_addr; d = bus.prga_wrdata; w = bus.prga_wren; end
            default: ;
        endcase
        if (m_phase != 0 && !m_fired && vis_rdy[2'(m_phase - 1)]) xen[2'(m_phase - 1)] = 1'b1;
        return {(m_phase == 0), 2'(m_phase), xen[0], xen[1], xen[2], m_key, a, d, w};
    endfunction

    function automatic logic [46:0] obs_vec();
        return {bus.rdy, bus.stage, bus.init_en, bus.ksa_en, bus.prga_en,
                bus.key_q, bus.s_addr, bus.s_wrdata, bus.s_wren};
    endfunction

    // ---------------- monitor ----------------
    int         pulse_cnt [3] = '{0, 0, 0};
    int         pulse_log [$];
    int         stage_log [$];
    logic [1:0] prev_stage = 2'd0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (xen_w[i]) begin
                pulse_cnt[i] <= pulse_cnt[i] + 1;
                pulse_log.push_back(i);
            end
        end
        if (bus.stage !== prev_stage) stage_log.push_back(int'(bus.stage));
        prev_stage <= bus.stage;
    end

    // Base-4 code of a logged sequence from index 'from' (entries offset by 'ofs')
    function automatic int seq_code(input int q[$], input int from, input int ofs);
        int code;
        code = 0;
        for (int k = from; k < q.size(); k++) code = code * 4 + q[k] + ofs;
        return code;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random_bus();
        bus.init_addr   = 8'($urandom);
        bus.ksa_addr    = 8'($urandom);
        bus.prga_addr   = 8'($urandom);
        bus.init_wrdata = 8'($urandom);
        bus.ksa_wrdata  = 8'($urandom);
        bus.prga_wrdata = 8'($urandom);
        bus.init_wren   = 1'($urandom);
        bus.ksa_wren    = 1'($urandom);
        bus.prga_wren   = 1'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [46:0] obs;
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.key = 24'hABCDEF;
        for (int c = 0; c < 3; c++) begin
            tick();
            drive_random_bus();
            bus.init_wren = 1'b1;
            bus.ksa_wren  = 1'b1;
            bus.prga_wren = 1'b1;
            if (c == 2) begin
                rst    = 1'b0;
                bus.en = 1'b0;
            end
            @(negedge clk);
            obs = obs_vec();
            vectors++;
            if (obs !== RESET_VEC) begin
                miscompares++;
                $display("FAIL reset_state c%0d: got %h want %h", c, obs, RESET_VEC);
            end
        end
    endtask

    task automatic test_nominal();
        logic [46:0] obs, expv;
        int p0, s0;
        bit done;
        p0   = pulse_log.size();
        s0   = stage_log.size();
        done = 1'b0;
        tick();
        bus.en  = 1'b1;
        bus.key = 24'h00033C;
        drive_random_bus();
        @(negedge clk);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL nominal_cycle c%0d: got %h want %h", c, obs, expv);
            end
            if (m_phase == 0) done = 1'b1;
        end
        tick();
        vectors++;
        if (!done) begin miscompares++; $display("FAIL nominal_timeout: run still busy, want idle"); end
        vectors++;
        if (seq_code(pulse_log, p0, 1) !== 27) begin
            miscompares++;
            $display("FAIL nominal_pulse_order: got code %0d (%0d pulses) want 27 (init,ksa,prga)",
                     seq_code(pulse_log, p0, 1), pulse_log.size() - p0);
        end
        vectors++;
        if (seq_code(stage_log, s0, 0) !== 108) begin
            miscompares++;
            $display("FAIL nominal_stage_trace: got code %0d want 108 (1,2,3,0)", seq_code(stage_log, s0, 0));
        end
        vectors++;
        if (bus.key_q !== 24'h00033C) begin
            miscompares++;
            $display("FAIL nominal_key_q: got %h want 00033c", bus.key_q);
        end
        vectors++;
        if (bus.rdy !== 1'b1) begin miscompares++; $display("FAIL nominal_rdy: got %b want 1", bus.rdy); end
    endtask

    task automatic test_busy_ksa();
        logic [46:0] obs, expv;
        int k0, blocked;
        bit done, ksa_seen;
        k0 = pulse_cnt[1];
        blocked = 0;
        done = 1'b0;
        ksa_seen = 1'b0;
        ksa_block_cycles = 4;
        tick();
        bus.en  = 1'b1;
        bus.key = 24'($urandom);
        drive_random_bus();
        @(negedge clk);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            @(negedge clk);
            if (bus.ksa_en === 1'b1) ksa_seen = 1'b1;
            else if (bus.stage === 2'd2 && !ksa_seen) blocked++;
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL busy_cycle c%0d: got %h want %h", c, obs, expv);
            end
            if (m_phase == 0) done = 1'b1;
        end
        tick();
        ksa_block_cycles = 0;
        vectors++;
        if (!done) begin miscompares++; $display("FAIL busy_timeout: run still busy, want idle"); end
        vectors++;
        if (blocked !== 4) begin
            miscompares++;
            $display("FAIL busy_hold: got %0d cycles without ksa_en want 4", blocked);
        end
        vectors++;
        if (pulse_cnt[1] - k0 !== 1) begin
            miscompares++;
            $display("FAIL busy_ksa_pulses: got %0d want 1", pulse_cnt[1] - k0);
        end
    endtask

    task automatic test_mux();
        logic [46:0] obs, expv;
        int hits;
        bit done;
        hits = 0;
        done = 1'b0;
        tick();
        bus.en  = 1'b1;
        bus.key = 24'($urandom);
        drive_random_bus();
        @(negedge clk);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            if (bus.stage === 2'd2) begin
                bus.ksa_addr   = 8'h10;
                bus.ksa_wrdata = 8'hAB;
                bus.ksa_wren   = 1'b1;
                bus.init_wren  = 1'b1;
                bus.prga_wren  = 1'b1;
            end
            @(negedge clk);
            if (bus.stage === 2'd2) begin
                hits++;
                vectors++;
                if ({bus.s_addr, bus.s_wrdata, bus.s_wren} !== {8'h10, 8'hAB, 1'b1}) begin
                    miscompares++;
                    $display("FAIL mux_ksa_owner: got %h/%h/%b want 10/ab/1",
                             bus.s_addr, bus.s_wrdata, bus.s_wren);
                end
            end
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL mux_cycle c%0d: got %h want %h", c, obs, expv);
            end
            if (m_phase == 0) done = 1'b1;
        end
        vectors++;
        if (!done || hits == 0) begin
            miscompares++;
            $display("FAIL mux_run: got done=%b stage2_cycles=%0d want done=1 and stage2 seen", done, hits);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            bus.init_wren = 1'b1;
            bus.ksa_wren  = 1'b1;
            bus.prga_wren = 1'b1;
            @(negedge clk);
            vectors++;
            if ({bus.s_addr, bus.s_wrdata, bus.s_wren} !== 17'h0) begin
                miscompares++;
                $display("FAIL mux_idle c%0d: got %h/%h/%b want 00/00/0",
                         c, bus.s_addr, bus.s_wrdata, bus.s_wren);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [46:0] obs, expv;
        logic [23:0] k1;
        int i0;
        bit done, injected;
        k1 = 24'($urandom_range(0, 24'hFFFFFE));
        i0 = pulse_cnt[0];
        done = 1'b0;
        injected = 1'b0;
        tick();
        bus.en  = 1'b1;
        bus.key = k1;
        drive_random_bus();
        @(negedge clk);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            if (!injected && m_phase == 1 && m_fired) begin
                bus.en   = 1'b1;
                bus.key  = 24'hFFFFFF;
                injected = 1'b1;
            end
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL ignored_cycle c%0d: got %h want %h", c, obs, expv);
            end
            if (m_phase == 0) done = 1'b1;
        end
        tick();
        vectors++;
        if (!done || !injected) begin
            miscompares++;
            $display("FAIL ignored_run: got done=%b injected=%b want 1/1", done, injected);
        end
        vectors++;
        if (bus.key_q !== k1) begin
            miscompares++;
            $display("FAIL ignored_key_q: got %h want %h", bus.key_q, k1);
        end
        vectors++;
        if (pulse_cnt[0] - i0 !== 1) begin
            miscompares++;
            $display("FAIL ignored_init_pulses: got %0d want 1", pulse_cnt[0] - i0);
        end
    endtask

    task automatic test_midrun_reset();
        logic [46:0] obs, expv;
        int q0;
        bit hit;
        hit = 1'b0;
        tick();
        bus.en  = 1'b1;
        bus.key = 24'($urandom_range(1, 24'hFFFFFF));
        drive_random_bus();
        @(negedge clk);
        for (int c = 0; c < 200 && !hit; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            if (m_phase == 2 && m_fired) begin
                rst = 1'b1;
                hit = 1'b1;
            end
            @(negedge clk);
        end
        q0 = pulse_cnt[2];
        tick();
        rst = 1'b0;
        drive_random_bus();
        @(negedge clk);
        obs = obs_vec();
        vectors++;
        if (!hit || obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL midrun_reset_state: got %h (hit=%b) want %h", obs, hit, RESET_VEC);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            drive_random_bus();
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL midrun_quiet c%0d: got %h want %h", c, obs, expv);
            end
        end
        tick();
        vectors++;
        if (pulse_cnt[2] - q0 !== 0) begin
            miscompares++;
            $display("FAIL midrun_prga_pulses: got %0d want 0", pulse_cnt[2] - q0);
        end
    endtask

    task automatic test_back_to_back();
        logic [46:0] obs, expv;
        int r0, c0 [3];
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3; i++) c0[i] = pulse_cnt[i];
        r0 = m_runs;
        for (int c = 0; c < 150; c++) begin
            tick();
            bus.en  = 1'b1;
            bus.key = 24'($urandom);
            drive_random_bus();
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL b2b_cycle c%0d: got %h want %h", c, obs, expv);
            end
        end
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            bus.en = 1'b0;
            drive_random_bus();
            @(negedge clk);
            if (m_phase == 0) done = 1'b1;
        end
        tick();
        vectors++;
        if (!done || m_runs - r0 < 2) begin
            miscompares++;
            $display("FAIL b2b_runs: got done=%b runs=%0d want done=1 runs>=2", done, m_runs - r0);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (pulse_cnt[i] - c0[i] !== m_runs - r0) begin
                miscompares++;
                $display("FAIL b2b_pulses eng%0d: got %0d want %0d", i, pulse_cnt[i] - c0[i], m_runs - r0);
            end
        end
    endtask

    task automatic test_random();
        logic [46:0] obs, expv;
        bit done;
        done = 1'b0;
        rand_dur = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            bus.en  = ($urandom_range(0, 99) < 30);
            bus.key = 24'($urandom);
            rst     = ($urandom_range(0, 99) < 2);
            drive_random_bus();
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_cycle c%0d: got %h want %h", c, obs, expv);
            end
        end
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            rst    = 1'b0;
            bus.en = 1'b0;
            drive_random_bus();
            @(negedge clk);
            obs  = obs_vec();
            expv = exp_vec();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_drain c%0d: got %h want %h", c, obs, expv);
            end
            if (m_phase == 0) done = 1'b1;
        end
        rand_dur = 1'b0;
        vectors++;
        if (!done) begin miscompares++; $display("FAIL random_timeout: run still busy, want idle"); end
    endtask

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.key = 24'h0;
        drive_random_bus();
        test_reset();
        test_nominal();
        test_busy_ksa();
        test_mux();
        test_ignored_start();
        test_midrun_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/arc4_sequencer.md
ARC4_SEQUENCER -- requirements
Module: arc4_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  start request; sampled only when rdy=1.
REQ-005 rdy  out  1  high when idle and able to accept en.
REQ-006 key  in  24  cipher key; latched on accepted en.
REQ-007 key_q  out  24  latched key, driven to the ksa and prga engines.
REQ-008 stage  out  2  active engine: 0 idle, 1 init, 2 ksa, 3 prga.
REQ-009 init_en, ksa_en, prga_en  out  1 each  one-cycle start pulse to the corresponding engine.
REQ-010 init_rdy, ksa_rdy, prga_rdy  in  1 each  engine idle/done indication.
REQ-011 init_addr/ksa_addr/prga_addr  in  8 each; init_wrdata/ksa_wrdata/prga_wrdata  in  8 each; init_wren/ksa_wren/prga_wren  in  1 each  engine requests to S memory.
REQ-012 s_addr  out  8;  s_wrdata  out  8;  s_wren  out  1  single S-memory port.

Function
REQ-013 Engine handshake SHALL be: an engine with rdy=1 samples en=1 at an edge, drives rdy=0 from that edge, and re-drives rdy=1 when finished.
REQ-014 FSM states SHALL be IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA.
REQ-015 IDLE: rdy=1, stage=0; on en=1 latch key into key_q and go to START_INIT; otherwise stay.
REQ-016 START_x: drive x_en=1 only while x_rdy=1; on the edge where x_en=1 go to WAIT_x; while x_rdy=0, hold with x_en=0.
REQ-017 WAIT_x: all x_en=0; on x_rdy=1 go to START of the next engine (init->ksa->prga), or from WAIT_PRGA to IDLE.
REQ-018 At most one x_en SHALL be high in any cycle, for exactly one cycle per engine run.
REQ-019 rdy SHALL be 0 in every state except IDLE; en while rdy=0 SHALL be ignored and key_q SHALL NOT change.
REQ-020 stage SHALL be 1 in START_INIT/WAIT_INIT, 2 in START_KSA/WAIT_KSA, 3 in START_PRGA/WAIT_PRGA.
REQ-021 S-memory mux SHALL be combinational, zero latency, selected by stage: the owning engine's addr/wrdata/wren pass straight to s_addr/s_wrdata/s_wren.
REQ-022 Non-owning engines' wren SHALL be blocked; stage=0 SHALL drive s_addr=0, s_wrdata=0, s_wren=0.
REQ-023 key_q SHALL hold its value from acceptance until the next accepted en, including through IDLE.
REQ-024 en=1 arriving in the same cycle that WAIT_PRGA returns to IDLE SHALL be ignored; it is accepted only when sampled in IDLE.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, regardless of current state.
REQ-026 After reset: rdy=1, stage=0, key_q=0, all x_en=0, s_addr=0, s_wrdata=0, s_wren=0.
REQ-027 Reset mid-run SHALL NOT emit further x_en pulses; a new run begins only on a fresh accepted en.

Verification
REQ-028 Nominal: reset, en=1 with key=24'h00033C, engines each finish 5 cycles after their en -> init_en, ksa_en, prga_en each pulse exactly once in order; key_q=24'h00033C; stage 1->2->3->0; rdy returns to 1.
REQ-029 Busy engine: ksa_rdy held 0 for 4 cycles on entry to START_KSA -> ksa_en stays 0 those cycles, then pulses once when ksa_rdy=1.
REQ-030 Mux isolation: during stage=2 drive ksa_addr=8'h10, ksa_wrdata=8'hAB, ksa_wren=1, init_wren=1, prga_wren=1 -> s_addr=8'h10, s_wrdata=8'hAB, s_wren=1; at stage=0 all s_* = 0 despite any engine wren=1.
REQ-031 Ignored start: en=1 with key=24'hFFFFFF during WAIT_INIT -> no effect; key_q keeps prior value; no extra init_en.
REQ-032 Mid-run reset: rst=1 for one cycle in WAIT_KSA -> next cycle rdy=1, stage=0, key_q=0, no prga_en ever pulses until a new en is accepted.
REQ-033 Back-to-back: en held high continuously -> second run starts only after rdy is seen 1 in IDLE; exactly 3 x_en pulses per run.
